// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//
// Shared types and constants for the pushbutton debouncer.
//   kd_state_e    : per-channel qualification FSM state
//   SYNC_RST_VAL  : reset value of both synchroniser flops (key released)
//   kd_max        : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,  // stable released
    ST_CHK_DN = 2'd1,  // qualifying a press
    ST_DOWN   = 2'd2,  // stable pressed
    ST_CHK_UP = 2'd3   // qualifying a release
  } kd_state_e;

  // Keys are active-low, so "released" is the safe value out of reset.
  localparam logic SYNC_RST_VAL = 1'b1;

  function automatic int kd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// -----------------------------------------------------------------------------
// key_debounce_chan
//
// One pushbutton channel: 2-flop synchroniser, stable-time qualification FSM
// and registered press/release strobes.
//
// Optional feature macro: KEY_DEBOUNCE_AUTOREPEAT_EN
//   When defined, a held key re-fires press_o REPEAT_DELAY cycles after the
//   accepted press and then every REPEAT_CYCLES while it stays down.
//
// Ports
//   clk        in  : system clock
//   reset      in  : synchronous, active-high reset
//   key_n_i    in  : raw key, active-low, asynchronous to clk
//   level_o    out : debounced level, active-low (1 = released)
//   press_o    out : one-cycle strobe per accepted press (and repeat)
//   release_o  out : one-cycle strobe per accepted release
// -----------------------------------------------------------------------------
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The edge that would bring the count to DEBOUNCE_CYCLES is the accepting
  // edge, so the FSM compares against one less than the stable time.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MIN = 1;
`else
  localparam int RPT_MIN = 0;
`endif

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((REPEAT_DELAY < RPT_MIN) || (REPEAT_CYCLES < RPT_MIN)) begin : g_bad_repeat
    $error("key_debounce_chan: REPEAT_DELAY/REPEAT_CYCLES out of range");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= SYNC_RST_VAL;
      sync_q <= SYNC_RST_VAL;
    end else begin
      meta_q <= key_n_i;
      sync_q <= meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Qualification FSM
  // ---------------------------------------------------------------------------
  kd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rpt_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_UP;
      cnt_q     <= '0;
      stable_q  <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_UP: begin
        cnt_d = '0;
        if (!sync_q) begin
          state_d = ST_CHK_DN;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_DN: begin
        if (sync_q) begin
          state_d = ST_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        cnt_d = '0;
        if (sync_q) begin
          state_d = ST_CHK_UP;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_UP: begin
        if (!sync_q) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_UP;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed here and registered above, so nothing combinational
  // reaches the ports.
  always_comb begin
    logic accept_press;
    logic accept_release;
    accept_press   = (state_q == ST_CHK_DN) && !sync_q && (cnt_q == CNT_LAST);
    accept_release = (state_q == ST_CHK_UP) &&  sync_q && (cnt_q == CNT_LAST);
    stable_d  = stable_q;
    if (accept_press) begin
      stable_d = 1'b0;
    end else if (accept_release) begin
      stable_d = 1'b1;
    end
    press_d   = accept_press | rpt_fire;
    release_d = accept_release;
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
  localparam int RPT_W = $clog2(kd_max(REPEAT_DELAY, REPEAT_CYCLES) + 1);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_CYCLES);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  // Counts only while the channel sits in DOWN with the key still low; the
  // edge that leaves DOWN (or re-enters it from CHK_UP) clears it, so a
  // release can never be followed by a repeat and a bounce restarts the delay.
  always_comb begin
    logic [RPT_W-1:0] target;
    target      = rpt_first_q ? RPT_FIRST : RPT_NEXT;
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_fire    = 1'b0;
    if ((state_q == ST_DOWN) && !sync_q) begin
      if ((rpt_cnt_q + RPT_ONE) == target) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + RPT_ONE;
        rpt_first_d = rpt_first_q;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Debounces and synchronises NUM_KEYS active-low pushbuttons. key_level feeds
// the Keys parallel-input port so its edge capture sees one edge per physical
// press or release; press_pulse/release_pulse serve hardware consumers.
//
// Optional feature macro: KEY_DEBOUNCE_AUTOREPEAT_EN (auto-repeat on press_pulse)
//
// Ports
//   clk            in  : system clock
//   reset          in  : synchronous, active-high reset
//   key_n_in       in  : raw keys [NUM_KEYS-1:0], active-low, asynchronous
//   key_level      out : debounced levels, active-low (1 = released)
//   press_pulse    out : one-cycle strobe per accepted press (and repeat)
//   release_pulse  out : one-cycle strobe per accepted release
// -----------------------------------------------------------------------------
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .key_n_i   (key_n_in[k]),
      .level_o   (key_level[k]),
      .press_o   (press_pulse[k]),
      .release_o (release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n_in      (key_n_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rls;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_presses   = 0;
  int   dut_presses = 0;

  // Reference model: a key's accepted level flips once the value seen two
  // samples late has differed from it for DB consecutive clocks. Auto-repeat
  // fires on hold-time milestones RD, RD+RC, RD+2RC, ...
  logic [NK-1:0] m_meta, m_sync, m_stable;
  int            m_run [NK];
  int            m_hold[NK];

  always @(posedge clk) begin : model
    exp_t e;
    logic s;
    e.prs = '0;
    e.rls = '0;
    if (reset) begin
      m_meta   = '1;
      m_sync   = '1;
      m_stable = '1;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  = 0;
        m_hold[k] = 0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        s = m_sync[k];
        if (s != m_stable[k]) begin
          m_run[k]++;
          m_hold[k] = 0;
          if (m_run[k] == DB) begin
            m_stable[k] = s;
            m_run[k]    = 0;
            if (s == 1'b0) e.prs[k] = 1'b1;
            else           e.rls[k] = 1'b1;
          end
        end else if (m_run[k] != 0) begin
          m_run[k]  = 0;
          m_hold[k] = 0;
        end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        else if (m_stable[k] == 1'b0) begin
          m_hold[k]++;
          if (m_hold[k] == RD || (m_hold[k] > RD && ((m_hold[k] - RD) % RC) == 0))
            e.prs[k] = 1'b1;
        end
`endif
      end
      m_sync = m_meta;
      m_meta = key_n_in;
    end
    e.lvl = m_stable;
    exp_q.push_back(e);
    m_presses += $countones(e.prs);
  end

  // Monitor: every post-edge cycle the DUT presents a result that is compared
  // with the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      dut_presses += $countones(press_pulse);
      checks++;
      if (key_level !== e.lvl) begin
        errors++;
        $display("FAIL level cyc=%0d act=%h req=%h", cyc, key_level, e.lvl);
      end
      checks++;
      if (press_pulse !== e.prs) begin
        errors++;
        $display("FAIL press cyc=%0d act=%h req=%h", cyc, press_pulse, e.prs);
      end
      checks++;
      if (release_pulse !== e.rls) begin
        errors++;
        $display("FAIL release cyc=%0d act=%h req=%h", cyc, release_pulse, e.rls);
      end
      checks++;
      if ((press_pulse & release_pulse) !== '0) begin
        errors++;
        $display("FAIL both_strobes cyc=%0d act=%h req=0", cyc, press_pulse & release_pulse);
      end
    end
  end

  task automatic drive(input logic [NK-1:0] v, input int n);
    key_n_in = v;
    repeat (n) @(negedge clk);
  endtask

  int            rem[NK];
  logic [NK-1:0] rv;

  initial begin
    reset    = 1'b1;
    key_n_in = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle
    drive(4'hF, 50);
    // clean press and release on key0
    drive(4'hE, 20);
    drive(4'hF, 20);
    // bouncy press: 5 low, 2 high, 12 low
    drive(4'hE, 5);
    drive(4'hF, 2);
    drive(4'hE, 12);
    drive(4'hF, 20);
    // keys 1 and 3 together
    drive(4'b0101, 20);
    drive(4'hF, 20);
    // reset while key0 is mid-qualification (counter at 5)
    key_n_in = 4'hE;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(4'hE, 20);
    drive(4'hF, 20);
    // long hold on key2 (auto-repeat window), then release
    drive(4'b1011, 75);
    drive(4'hF, 30);
    // bounce on key2 during hold restarts the repeat delay
    drive(4'b1011, 30);
    drive(4'hF, 3);
    drive(4'b1011, 40);
    drive(4'hF, 30);

    // independent random bouncing on all keys
    rv = '1;
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          rv[k]  = 1'($urandom_range(0, 1));
          rem[k] = $urandom_range(1, 14);
        end
        rem[k]--;
      end
      key_n_in = rv;
      @(negedge clk);
    end
    drive(4'hF, 40);
    #1;

    checks++;
    if (dut_presses != m_presses) begin
      errors++;
      $display("FAIL press_total act=%0d req=%0d", dut_presses, m_presses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
